// File: rtl/spi_ram_arbiter.sv
// rtl/spi_ram_arbiter.sv - round-robin arbiter for two requesters sharing a 256x8 single-port RAM
// Optional macro ARB_FIXED_PRIORITY_EN: requester 0 always wins ties instead of round-robin.
module spi_ram_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       we0,
  input  logic [7:0] addr0,
  input  logic [7:0] wdata0,
  output logic       ack0,
  output logic [7:0] rdata0,
  input  logic       req1,
  input  logic       we1,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata1,
  output logic       ack1,
  output logic [7:0] rdata1,
  output logic       ram_en,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, ACK} state_t;

  state_t state;
  logic   winner;
  logic   wr;
  logic   pick;

`ifdef ARB_FIXED_PRIORITY_EN
  assign pick = req0 ? 1'b0 : 1'b1;
`else
  logic last_grant;
  // on a tie, the requester that did not win last time goes next
  assign pick = (req0 && req1) ? ~last_grant : req1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      winner    <= 1'b0;
      wr        <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= 8'h00;
      rdata1    <= 8'h00;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= 8'h00;
      ram_wdata <= 8'h00;
`ifdef ARB_FIXED_PRIORITY_EN
`else
      last_grant <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            winner    <= pick;
            wr        <= pick ? we1 : we0;
            ram_en    <= 1'b1;
            ram_we    <= pick ? we1 : we0;
            ram_addr  <= pick ? addr1 : addr0;
            ram_wdata <= pick ? wdata1 : wdata0;
`ifdef ARB_FIXED_PRIORITY_EN
`else
            last_grant <= pick;
`endif
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          ram_en <= 1'b0;
          ram_we <= 1'b0;
          state  <= wr ? ACK : RWAIT;
        end
        RWAIT: begin
          // RAM output is valid one cycle after the strobe
          if (winner) rdata1 <= ram_rdata;
          else        rdata0 <= ram_rdata;
          state <= ACK;
        end
        ACK: begin
          if (winner) ack1 <= 1'b1;
          else        ack0 <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb/tb_spi_ram_arbiter.sv - self-checking bench for spi_ram_arbiter with a RAM model and transaction-level reference
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, we0, req1, we1;
  logic [7:0] addr0, wdata0, addr1, wdata1;
  logic       ack0, ack1, ram_en, ram_we;
  logic [7:0] rdata0, rdata1, ram_addr, ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  spi_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // synchronous 256x8 RAM with one-cycle read latency
  logic [7:0] ram [256];
  logic       ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
      ram_rdata <= 8'h00;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // reference model state
  logic [7:0] mem_ref [256];
  logic       lg_ref;

  typedef struct {
    int         id;
    int         n;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } ev_t;

  function automatic int choose(input logic p0, input logic p1);
`ifdef ARB_FIXED_PRIORITY_EN
    return p0 ? 0 : 1;
`else
    if (p0 && p1) return (lg_ref == 1'b1) ? 0 : 1;
    return p0 ? 0 : 1;
`endif
  endfunction

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lg_ref = 1'b1;
  endtask

  // Requesters hold req until their ack; expected events come from the transaction model.
  task automatic run_txn(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                         output int first);
    ev_t exp_q[$];
    ev_t acc_q[$];
    ev_t e;
    logic p0, p1;
    int   s, n, w;
    p0 = r0; p1 = r1; s = 1; n = 0;
    while (p0 || p1) begin
      w = choose(p0, p1);
      lg_ref = w[0];
      e.id    = w;
      e.we    = w[0] ? w1 : w0;
      e.addr  = w[0] ? a1 : a0;
      e.wdata = w[0] ? d1 : d0;
      e.rdata = mem_ref[e.addr];
      if (e.we) mem_ref[e.addr] = e.wdata;
      e.n = s + (e.we ? 2 : 3);
      s = e.n + 1;
      if (w[0]) p1 = 1'b0; else p0 = 1'b0;
      exp_q.push_back(e);
    end
    acc_q = exp_q;
    first = -1;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    while (exp_q.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
      if (ram_en) begin
        check("access_expected", acc_q.size() != 0, 1);
        if (acc_q.size() != 0) begin
          e = acc_q.pop_front();
          check("access_fields", {ram_we, ram_addr, ram_wdata}, {e.we, e.addr, e.wdata});
        end
      end
      check("ack_overlap", ack0 & ack1, 0);
      if (ack0 || ack1) begin
        e = exp_q.pop_front();
        if (first < 0) first = ack1 ? 1 : 0;
        check("ack_id", ack1, e.id);
        check("ack_cycle", n, e.n);
        if (!e.we) check("ack_rdata", ack1 ? rdata1 : rdata0, e.rdata);
        if (ack1) req1 = 1'b0; else req0 = 1'b0;
      end
    end
    check("ack_timeout", exp_q.size(), 0);
    req0 = 1'b0; req1 = 1'b0;
  endtask

  typedef struct {
    logic       r0, w0;
    logic [7:0] a0, d0;
    logic       r1, w1;
    logic [7:0] a1, d1;
    int         first;
    logic [7:0] rd0, rd1;
  } vec_t;

  vec_t tbl [8];
  int   first, t0, t1, f6, nack;
  int   order [4];
  logic [7:0] got_rd1;

  initial begin
`ifdef ARB_FIXED_PRIORITY_EN
    f6 = 0;
`else
    f6 = 1;
`endif
    tbl[0] = '{1'b1, 1'b1, 8'h1F, 8'hAA, 1'b0, 1'b0, 8'h00, 8'h00, 0,  8'h00, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h1F, 8'h00, 1,  8'h00, 8'hAA};
    tbl[2] = '{1'b1, 1'b1, 8'h20, 8'h55, 1'b1, 1'b1, 8'h21, 8'h66, 0,  8'h00, 8'hAA};
    tbl[3] = '{1'b1, 1'b0, 8'h21, 8'h00, 1'b1, 1'b0, 8'h20, 8'h00, 0,  8'h66, 8'h55};
    tbl[4] = '{1'b1, 1'b0, 8'h1F, 8'h00, 1'b1, 1'b1, 8'h1F, 8'h3C, 0,  8'hAA, 8'h55};
    tbl[5] = '{1'b1, 1'b0, 8'h1F, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 0,  8'h3C, 8'h55};
    tbl[6] = '{1'b1, 1'b1, 8'h00, 8'h01, 1'b1, 1'b0, 8'h1F, 8'h00, f6, 8'h3C, 8'h3C};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1,  8'h3C, 8'h01};

    for (int i = 0; i < 256; i++) mem_ref[i] = 8'(i) ^ 8'h5A;
    ram_init = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = 8'h00; wdata0 = 8'h00;
    req1 = 1'b0; we1 = 1'b0; addr1 = 8'h00; wdata1 = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    ram_init = 1'b0;
    check("reset_acks", {ack0, ack1}, 0);
    check("reset_rdata", {rdata0, rdata1}, 0);
    check("reset_ram", {ram_en, ram_we, ram_addr, ram_wdata}, 0);
    rst_n = 1'b1;
    lg_ref = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
              tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, first);
      check("tbl_first", first, tbl[i].first);
      check("tbl_rdata0", rdata0, tbl[i].rd0);
      check("tbl_rdata1", rdata1, tbl[i].rd1);
    end

    // req1 arrives while requester 0 is in ACCESS
    do_reset();
    t0 = -1; t1 = -1; got_rd1 = 8'h00;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'h40; wdata0 = 8'h77;
    for (int n = 1; n <= 15; n++) begin
      @(negedge clk);
      if (n == 1) begin req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40; end
      if (ack0) begin t0 = n; req0 = 1'b0; end
      if (ack1) begin t1 = n; got_rd1 = rdata1; req1 = 1'b0; end
    end
    mem_ref[8'h40] = 8'h77;
    lg_ref = 1'b1;
    check("late_req_ack0_cycle", t0, 3);
    check("late_req_ack1_cycle", t1, 7);
    check("late_req_rdata1", got_rd1, 8'h77);

    // both requesters held continuously from reset
    do_reset();
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'h1F;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
    nack = 0;
    for (int n = 0; n < 30 && nack < 4; n++) begin
      @(negedge clk);
      check("held_ack_overlap", ack0 & ack1, 0);
      if (ack0 || ack1) begin
        order[nack] = ack1 ? 1 : 0;
        nack++;
      end
    end
    check("held_ack_count", nack, 4);
`ifdef ARB_FIXED_PRIORITY_EN
    check("held_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0000);
`else
    check("held_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);
`endif
    req0 = 1'b0; req1 = 1'b0;
    repeat (6) @(negedge clk);

    // reset pulse during RWAIT of a read
    do_reset();
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'h40;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rwait_reset_rdata1", rdata1, 0);
    check("rwait_reset_acks", {ack0, ack1}, 0);
    check("rwait_reset_ram_en", ram_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    req1 = 1'b0;
    lg_ref = 1'b1;
    nack = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack0 || ack1) nack++;
    end
    check("rwait_reset_no_ack", nack, 0);
    run_txn(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00, first);
    check("rwait_reset_recover", rdata1, 8'h77);

    // randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      logic rr0, rr1;
      rr0 = 1'($urandom_range(0, 1));
      rr1 = 1'($urandom_range(0, 1));
      if (!rr0 && !rr1) rr0 = 1'b1;
      run_txn(rr0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom),
              rr1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom), first);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
